huffman_decoder: RTL and testbench

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

---
 rtl/huffman_decoder_pkg.sv | 19 +
 rtl/huffman_match.sv | 41 ++++
 rtl/huffman_decoder.sv | 118 +++++++++++
 tb/tb_huffman_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/huffman_decoder_pkg.sv
// Shared definitions for the serial prefix-code decoder.
package huffman_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [1:0] SYM_A = 2'd0;
  localparam logic [1:0] SYM_B = 2'd1;
  localparam logic [1:0] SYM_C = 2'd2;
  localparam logic [1:0] SYM_D = 2'd3;

  localparam int unsigned MAX_LEN = 3;
  localparam int unsigned N_SYM   = 4;

endpackage

// File: rtl/huffman_match.sv
// Combinational prefix matcher: finds the lowest-index table entry whose
// length equals the current bit count and whose low code bits equal the prefix.
module huffman_match
  import huffman_decoder_pkg::*;
(
  input  logic [15:0] code_table,
  input  logic [7:0]  len_table,
  input  logic [2:0]  prefix,
  input  logic [1:0]  count,
  output logic        hit,
  output logic [1:0]  index
);

  logic [2:0] mask;

  // Mask selecting the low 'count' bits of a code.
  always_comb begin
    mask = '0;
    case (count)
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      2'd3:    mask = 3'b111;
      default: mask = '0;
    endcase
  end

  // Scan from the highest index down so the lowest matching index is written last.
  always_comb begin
    hit   = 1'b0;
    index = SYM_A;
    for (int unsigned k = 0; k < N_SYM; k++) begin
      if ((count != 2'd0) &&
          (len_table[2*(N_SYM-1-k) +: 2] == count) &&
          ((code_table[4*(N_SYM-1-k) +: 4] & {1'b0, mask}) == ({1'b0, prefix} & {1'b0, mask}))) begin
        hit   = 1'b1;
        index = 2'(N_SYM - 1 - k);
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for a loadable four-symbol code table with
// valid/ready handshakes on both the bit input and the symbol output.
module huffman_decoder
  import huffman_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [15:0]      CODE_TABLE,
  input  logic [7:0]       LEN_TABLE,
  input  logic             BIT_IN,
  input  logic             BIT_VALID,
  output logic             BIT_READY,
  output logic [1:0]       SYM,
  output logic             SYM_VALID,
  input  logic             SYM_READY,
  output logic             ERROR,
  output logic [CNT_W-1:0] SYM_COUNT
);

  state_t           state, state_next;
  logic [15:0]      code_tbl;
  logic [7:0]       len_tbl;
  logic [2:0]       shreg;
  logic [1:0]       bit_cnt;
  logic [1:0]       sym_q;
  logic [CNT_W-1:0] sym_count_q;

  logic       bit_ready;
  logic       bit_take;
  logic       sym_take;
  logic [2:0] next_prefix;
  logic [1:0] next_cnt;
  logic       hit;
  logic [1:0] hit_index;

  assign bit_ready   = (state == DECODE) && !LOAD;
  assign bit_take    = BIT_VALID && bit_ready;
  // LOAD discards a pending symbol, so it also blocks the transfer.
  assign sym_take    = (state == HOLD) && SYM_READY && !LOAD;
  assign next_prefix = 3'({shreg, BIT_IN});
  assign next_cnt    = bit_cnt + 2'd1;

  huffman_match u_match (
    .code_table (code_tbl),
    .len_table  (len_tbl),
    .prefix     (next_prefix),
    .count      (next_cnt),
    .hit        (hit),
    .index      (hit_index)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; LOAD overrides every state.
  always_comb begin
    state_next = state;
    if (LOAD) begin
      state_next = DECODE;
    end else begin
      case (state)
        DECODE: begin
          if (bit_take) begin
            if (hit)                          state_next = HOLD;
            else if (next_cnt == 2'(MAX_LEN)) state_next = ERR;
          end
        end
        HOLD:    if (sym_take) state_next = DECODE;
        default: state_next = state;
      endcase
    end
  end

  // Outputs derived from state and registered datapath.
  always_comb begin
    BIT_READY = bit_ready;
    SYM_VALID = (state == HOLD);
    ERROR     = (state == ERR);
    SYM       = sym_q;
    SYM_COUNT = sym_count_q;
  end

  // Table latch, shift register, bit count, symbol and symbol counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      code_tbl    <= '0;
      len_tbl     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      sym_q       <= '0;
      sym_count_q <= '0;
    end else if (LOAD) begin
      code_tbl <= CODE_TABLE;
      len_tbl  <= LEN_TABLE;
      shreg    <= '0;
      bit_cnt  <= '0;
    end else begin
      if (bit_take) begin
        if (hit || (next_cnt == 2'(MAX_LEN))) begin
          shreg   <= '0;
          bit_cnt <= '0;
        end else begin
          shreg   <= next_prefix;
          bit_cnt <= next_cnt;
        end
        if (hit) sym_q <= hit_index;
      end
      if (sym_take) sym_count_q <= sym_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed, table-driven bench for huffman_decoder.
module tb_huffman_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] CODE_TABLE = 16'h7620;
  logic [7:0]  LEN_TABLE = 8'hF9;
  logic        BIT_IN = 1'b0;
  logic        BIT_VALID = 1'b0;
  logic        BIT_READY;
  logic [1:0]  SYM;
  logic        SYM_VALID;
  logic        SYM_READY = 1'b1;
  logic        ERROR;
  logic [11:0] SYM_COUNT;

  int n_total = 0;
  int n_pass  = 0;

  huffman_decoder #(.CNT_W(12)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD       (LOAD),
    .CODE_TABLE (CODE_TABLE),
    .LEN_TABLE  (LEN_TABLE),
    .BIT_IN     (BIT_IN),
    .BIT_VALID  (BIT_VALID),
    .BIT_READY  (BIT_READY),
    .SYM        (SYM),
    .SYM_VALID  (SYM_VALID),
    .SYM_READY  (SYM_READY),
    .ERROR      (ERROR),
    .SYM_COUNT  (SYM_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       rst;
    bit       load;
    bit [7:0] len;
    bit       bv;
    bit       b;
    bit       sr;
    bit       rdy;   // BIT_READY before the edge
    bit       sv;    // SYM_VALID after the edge
    bit [1:0] sym;
    bit       csym;  // check SYM after the edge
    bit       err;
    int       cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit rst, bit load, bit [7:0] len, bit bv, bit b, bit sr,
                              bit rdy, bit sv, bit [1:0] sym, bit csym, bit err, int cnt);
    vec_t v;
    v.rst = rst; v.load = load; v.len = len; v.bv = bv; v.b = b; v.sr = sr;
    v.rdy = rdy; v.sv = sv; v.sym = sym; v.csym = csym; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset with a bit offered: nothing may be accepted.
    BIT_VALID = 1'b1;
    tick();
    tick();
    chk("reset BIT_READY", int'(BIT_READY), 0);
    chk("reset SYM_VALID", int'(SYM_VALID), 0);
    chk("reset SYM",       int'(SYM), 0);
    chk("reset ERROR",     int'(ERROR), 0);
    chk("reset SYM_COUNT", int'(SYM_COUNT), 0);
    RST = 1'b0;
    BIT_VALID = 1'b0;

    //             rst load len   bv b sr | rdy sv sym csym err cnt
    // Basic stream 0 | 10 | 110 | 111 -> A B C D
    vq.push_back(mk(0, 1, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  1, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 0, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 2));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  1, 0, 0, 0, 0, 2));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  1, 0, 0, 0, 0, 2));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  1, 1, 2, 1, 0, 2));
    vq.push_back(mk(0, 0, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 3));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  1, 0, 0, 0, 0, 3));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  1, 0, 0, 0, 0, 3));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  1, 1, 3, 1, 0, 3));
    vq.push_back(mk(0, 0, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 4));
    // Back-pressure: symbol held, following bits not consumed
    vq.push_back(mk(0, 1, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 4));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 0,  1, 1, 0, 1, 0, 4));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 0,  0, 1, 0, 1, 0, 4));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 0,  0, 1, 0, 1, 0, 4));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  0, 0, 0, 0, 0, 5));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  1, 0, 0, 0, 0, 5));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  1, 1, 1, 1, 0, 5));
    vq.push_back(mk(0, 0, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 6));
    // Ambiguous table: lowest index wins, then invalid code 111
    vq.push_back(mk(0, 1, 8'h05, 0, 0, 1,  0, 0, 0, 0, 0, 6));
    vq.push_back(mk(0, 0, 8'h05, 1, 0, 1,  1, 1, 0, 1, 0, 6));
    vq.push_back(mk(0, 0, 8'h05, 0, 0, 1,  0, 0, 0, 0, 0, 7));
    vq.push_back(mk(0, 0, 8'h05, 1, 1, 1,  1, 0, 0, 0, 0, 7));
    vq.push_back(mk(0, 0, 8'h05, 1, 1, 1,  1, 0, 0, 0, 0, 7));
    vq.push_back(mk(0, 0, 8'h05, 1, 1, 1,  1, 0, 0, 0, 1, 7));
    vq.push_back(mk(0, 0, 8'h05, 1, 1, 1,  0, 0, 0, 0, 1, 7));
    vq.push_back(mk(0, 0, 8'h05, 1, 1, 1,  0, 0, 0, 0, 1, 7));
    // LOAD clears ERROR; LOAD during HOLD discards the symbol
    vq.push_back(mk(0, 1, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 7));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 0,  1, 1, 0, 1, 0, 7));
    vq.push_back(mk(0, 1, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 7));
    vq.push_back(mk(0, 0, 8'hF9, 1, 1, 1,  1, 0, 0, 0, 0, 7));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  1, 1, 1, 1, 0, 7));
    vq.push_back(mk(0, 0, 8'hF9, 0, 0, 1,  0, 0, 0, 0, 0, 8));
    // RST while a symbol is pending, then IDLE ignores bits
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  1, 1, 0, 1, 0, 8));
    vq.push_back(mk(1, 0, 8'hF9, 1, 0, 0,  0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  0, 0, 0, 1, 0, 0));
    // RST beats LOAD
    vq.push_back(mk(1, 1, 8'hF9, 1, 0, 1,  0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 8'hF9, 1, 0, 1,  0, 0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      RST        = vq[i].rst;
      LOAD       = vq[i].load;
      LEN_TABLE  = vq[i].len;
      BIT_VALID  = vq[i].bv;
      BIT_IN     = vq[i].b;
      SYM_READY  = vq[i].sr;
      #1;
      chk($sformatf("row%0d BIT_READY", i), int'(BIT_READY), int'(vq[i].rdy));
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d SYM_VALID", i), int'(SYM_VALID), int'(vq[i].sv));
      chk($sformatf("row%0d ERROR", i), int'(ERROR), int'(vq[i].err));
      chk($sformatf("row%0d SYM_COUNT", i), int'(SYM_COUNT), vq[i].cnt);
      if (vq[i].csym) chk($sformatf("row%0d SYM", i), int'(SYM), int'(vq[i].sym));
    end

    // Counter wrap: 4095 decodes reach 12'hFFF, one more wraps to 0.
    RST = 1'b1; LOAD = 1'b0; BIT_VALID = 1'b0; SYM_READY = 1'b1;
    tick();
    RST = 1'b0; LOAD = 1'b1; LEN_TABLE = 8'hF9;
    tick();
    LOAD = 1'b0;
    for (int n = 0; n < 4096; n++) begin
      BIT_VALID = 1'b1; BIT_IN = 1'b0;
      tick();
      BIT_VALID = 1'b0;
      tick();
      if (n == 4094) chk("wrap count at FFF", int'(SYM_COUNT), 12'hFFF);
    end
    chk("wrap count to 0", int'(SYM_COUNT), 0);
    chk("wrap SYM_VALID", int'(SYM_VALID), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
